// File: rtl/demux_1_to_6_reg.sv
// Registered 1-to-N distributor: each accepted word is steered to the channel named by
// in_sel and held in that channel's one-entry register until its consumer takes it.
module demux_1_to_6_reg #(
    parameter int WIDTH = 8,
    parameter int NCH   = 6,
    parameter int SEL_W = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic                 err_sel,
    output logic [CNT_W-1:0]     drop_cnt
);

    logic [NCH*WIDTH-1:0] data_r;
    logic [NCH-1:0]       valid_r;
    logic                 err_r;
    logic [CNT_W-1:0]     cnt_r;

    logic                 in_range_s;
    logic                 ready_s;
    logic [NCH-1:0]       load_s;
    logic                 drop_s;

    // Extra select bit keeps the range test correct when NCH equals 2**SEL_W.
    assign in_range_s = ({1'b0, in_sel} < (SEL_W + 1)'(NCH));

    // Acceptance decision: an in-range word needs room in its channel, an out-of-range word is always taken.
    always_comb begin
        ready_s = 1'b1;
        if (in_range_s) begin
            for (int k = 0; k < NCH; k++) begin
                if (in_sel == SEL_W'(k)) begin
                    ready_s = !valid_r[k] || out_ready[k];
                end else begin
                    ready_s = ready_s;
                end
            end
        end else begin
            ready_s = 1'b1;
        end
    end

    // Per-channel load strobes and the drop strobe for out-of-range words.
    always_comb begin
        load_s = '0;
        drop_s = 1'b0;
        if (in_valid && ready_s) begin
            if (in_range_s) begin
                for (int k = 0; k < NCH; k++) begin
                    load_s[k] = (in_sel == SEL_W'(k));
                end
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            load_s = '0;
            drop_s = 1'b0;
        end
    end

    // Channel holding registers: a load wins over a drain, so FULL-with-ready-and-load stays FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= '0;
            valid_r <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (load_s[k]) begin
                    data_r[k*WIDTH +: WIDTH] <= in_data;
                    valid_r[k]               <= 1'b1;
                end else if (out_ready[k]) begin
                    valid_r[k] <= 1'b0;
                end else begin
                    valid_r[k] <= valid_r[k];
                end
            end
        end
    end

    // Error pulse and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
            cnt_r <= '0;
        end else begin
            err_r <= drop_s;
            if (drop_s && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign in_ready  = ready_s;
    assign out_data  = data_r;
    assign out_valid = valid_r;
    assign err_sel   = err_r;
    assign drop_cnt  = cnt_r;

endmodule

// File: tb/tb_demux_1_to_6_reg.sv
// Bench for demux_1_to_6_reg: fixed vector table, directed corner sequences and
// random traffic compared against a mailbox-per-channel reference model.
module tb_demux_1_to_6_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] out_data;
    logic [5:0]  out_valid;
    logic [5:0]  out_ready;
    logic        err_sel;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one mailbox per channel plus the drop bookkeeping.
    bit  m_full [6];
    int  m_data [6];
    bit  m_err;
    int  m_cnt;

    demux_1_to_6_reg dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_sel  (err_sel),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 6; k++) begin
            m_full[k] = 0;
            m_data[k] = 0;
        end
        m_err = 0;
        m_cnt = 0;
    endtask

    task automatic check_outputs();
        logic [5:0] ev;
        for (int k = 0; k < 6; k++) begin
            ev[k] = m_full[k];
            check($sformatf("out_data[%0d]", k), 64'(out_data[k*8 +: 8]), 64'(m_data[k]));
        end
        check("out_valid", 64'(out_valid), 64'(ev));
        check("err_sel", 64'(err_sel), 64'(m_err));
        check("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
    endtask

    // One clock of traffic: drive, check in_ready before the edge, advance model, check after.
    task automatic step(input logic [7:0] d, input logic [2:0] s, input logic v,
                        input logic [5:0] r, output logic rdy_seen);
        bit exp_rdy;
        bit accepted;
        int ch;
        in_data = d; in_sel = s; in_valid = v; out_ready = r;
        ch = int'(s);
        #1;
        exp_rdy = (ch >= 6) ? 1'b1 : (!m_full[ch] || r[ch]);
        rdy_seen = in_ready;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        accepted = v && exp_rdy;
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            if (r[k]) m_full[k] = 0;
        end
        if (accepted && ch < 6) begin
            m_full[ch] = 1;
            m_data[ch] = int'(d);
        end
        m_err = accepted && (ch >= 6);
        if (m_err) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        check_outputs();
    endtask

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic [5:0] r;
        logic       exp_rdy;
        logic [5:0] exp_valid;
        int         ch;
        logic [7:0] exp_chd;
        logic       exp_err;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic rdy;
        rst_n = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
        model_reset();

        // Routing sweep followed by one out-of-range word.
        for (int k = 0; k < 6; k++) begin
            tbl[k] = '{d: 8'(10 * (k + 1)), s: 3'(k), r: 6'h3F, exp_rdy: 1'b1,
                       exp_valid: 6'(1 << k), ch: k, exp_chd: 8'(10 * (k + 1)),
                       exp_err: 1'b0, exp_cnt: 8'd0};
        end
        tbl[6] = '{d: 8'd100, s: 3'd7, r: 6'h3F, exp_rdy: 1'b1, exp_valid: 6'h00,
                   ch: 5, exp_chd: 8'd60, exp_err: 1'b1, exp_cnt: 8'd1};

        #12;
        check("reset out_valid", 64'(out_valid), 64'h0);
        check("reset out_data", 64'(out_data), 64'h0);
        check("reset drop_cnt", 64'(drop_cnt), 64'h0);
        check("reset err_sel", 64'(err_sel), 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].d, tbl[i].s, 1'b1, tbl[i].r, rdy);
            check($sformatf("vec%0d in_ready", i), 64'(rdy), 64'(tbl[i].exp_rdy));
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
            check($sformatf("vec%0d chdata", i), 64'(out_data[tbl[i].ch*8 +: 8]), 64'(tbl[i].exp_chd));
            check($sformatf("vec%0d err_sel", i), 64'(err_sel), 64'(tbl[i].exp_err));
            check($sformatf("vec%0d drop_cnt", i), 64'(drop_cnt), 64'(tbl[i].exp_cnt));
        end
        step(8'd0, 3'd0, 1'b0, 6'h3F, rdy);
        check("err_sel one cycle", 64'(err_sel), 64'h0);

        // Backpressure on channel 2 stalls the producer; channel 3 is reached only afterwards.
        step(8'd30, 3'd2, 1'b1, 6'h3B, rdy);
        check("bp first accept", 64'(rdy), 64'h1);
        for (int i = 0; i < 2; i++) begin
            step(8'd33, 3'd2, 1'b1, 6'h3B, rdy);
            check("bp stall in_ready", 64'(rdy), 64'h0);
            check("bp ch2 held", 64'(out_data[23:16]), 64'd30);
            check("bp ch3 untouched", 64'(out_valid[3]), 64'h0);
        end
        step(8'd33, 3'd2, 1'b1, 6'h3F, rdy);
        check("bp release in_ready", 64'(rdy), 64'h1);
        check("bp ch2 reload", 64'(out_data[23:16]), 64'd33);
        check("bp ch2 valid", 64'(out_valid[2]), 64'h1);
        step(8'd40, 3'd3, 1'b1, 6'h3B, rdy);
        check("bp ch3 load", 64'(out_data[31:24]), 64'd40);

        // Back-to-back replacement on channel 1 without a bubble.
        step(8'd7, 3'd1, 1'b1, 6'h00, rdy);
        check("b2b ch1 first", 64'(out_data[15:8]), 64'd7);
        step(8'd8, 3'd1, 1'b1, 6'h02, rdy);
        check("b2b in_ready", 64'(rdy), 64'h1);
        check("b2b valid", 64'(out_valid[1]), 64'h1);
        check("b2b data", 64'(out_data[15:8]), 64'd8);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                 6'($urandom), rdy);
        end

        // Asynchronous reset in the middle of traffic with channels full.
        step(8'h55, 3'd0, 1'b1, 6'h00, rdy);
        step(8'h66, 3'd4, 1'b1, 6'h00, rdy);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 64'(out_valid), 64'h0);
        check("async rst out_data", 64'(out_data), 64'h0);
        check("async rst drop_cnt", 64'(drop_cnt), 64'h0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Drop counter saturation, then normal routing still works.
        for (int i = 0; i < 260; i++) begin
            step(8'(i), 3'd6, 1'b1, 6'h3F, rdy);
        end
        check("sat drop_cnt", 64'(drop_cnt), 64'd255);
        step(8'd100, 3'd0, 1'b1, 6'h3F, rdy);
        check("sat ch0 data", 64'(out_data[7:0]), 64'd100);
        check("sat ch0 valid", 64'(out_valid[0]), 64'h1);
        check("sat drop_cnt hold", 64'(drop_cnt), 64'd255);
        step(8'd0, 3'd0, 1'b0, 6'h3F, rdy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
